// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched
//   Hazard and sequencing controller for the 5-stage (F,D,E,M,W) scalar/vector
//   pipeline. It produces the stall and flush enables for the F/D, D/E and E/M
//   pipeline registers and the E-stage forwarding selects. It also sequences
//   multi-pass vector ops: the E ALU computes LANES_PER_PASS lanes per cycle,
//   so a vector op is held in D/E for PASSES cycles.
//
// Ports
//   i_clk, i_rst              clock (rising edge), async active-high reset
//   i_ra1d, i_ra2d, i_v_s_d   D-stage sources and vector/scalar class
//   i_valid_e                 E holds a real instruction
//   i_wa3e, i_reg_write_e     E destination and write enable
//   i_mem_to_reg_e, i_v_s_e   E is a load / E is vector
//   i_pcsrc_e                 taken branch resolved in E
//   i_ra1e, i_ra2e            E sources (forwarding)
//   i_wa3m/w, i_reg_write_m/w M/W destinations and write enables
//   i_v_s_m, i_v_s_w          M/W vector/scalar class
//   o_stall_f/d/e             hold PC, F/D, D/E
//   o_flush_d/e               clear F/D, D/E on the next edge
//   o_bubble_m                E/M loads a bubble on the next edge
//   o_forward_ae/be           00 register file, 10 ALUResultM, 01 ResultW
//   o_lane_grp                lane group computed by E this cycle
//   o_vec_busy                vector op is in its multi-pass sequence
//
// State | meaning
//   IDLE  | no sequence in progress; E (if vector) is on pass 0
//   VEXEC | vector op on pass r_pass_cnt (1 .. PASSES-1)

module pipe_hazard_sched #(
    parameter int NUM_LANES      = 16,
    parameter int LANES_PER_PASS = 4,
    parameter int REG_ADDR_W     = 4,
    localparam int PASSES        = NUM_LANES / LANES_PER_PASS,
    localparam int GRP_W         = (PASSES > 1) ? $clog2(PASSES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_ra1d,
    input  logic [REG_ADDR_W-1:0] i_ra2d,
    input  logic                  i_v_s_d,
    input  logic                  i_valid_e,
    input  logic [REG_ADDR_W-1:0] i_wa3e,
    input  logic                  i_reg_write_e,
    input  logic                  i_mem_to_reg_e,
    input  logic                  i_v_s_e,
    input  logic                  i_pcsrc_e,
    input  logic [REG_ADDR_W-1:0] i_ra1e,
    input  logic [REG_ADDR_W-1:0] i_ra2e,
    input  logic [REG_ADDR_W-1:0] i_wa3m,
    input  logic [REG_ADDR_W-1:0] i_wa3w,
    input  logic                  i_reg_write_m,
    input  logic                  i_reg_write_w,
    input  logic                  i_v_s_m,
    input  logic                  i_v_s_w,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_stall_e,
    output logic                  o_flush_d,
    output logic                  o_flush_e,
    output logic                  o_bubble_m,
    output logic [1:0]            o_forward_ae,
    output logic [1:0]            o_forward_be,
    output logic [GRP_W-1:0]      o_lane_grp,
    output logic                  o_vec_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VEXEC = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [GRP_W-1:0] r_pass_cnt;
    logic [GRP_W-1:0] w_pass_cnt_nxt;
    logic             w_vec_e;
    logic             w_seq_stall;
    logic             w_ldstall;
    logic             w_stall_f;

    // Scalar and vector register files share an address encoding but are
    // distinct storage, so a class mismatch never counts as a hit.
    function automatic logic f_match(
        input logic [REG_ADDR_W-1:0] a,
        input logic                  v,
        input logic [REG_ADDR_W-1:0] wa,
        input logic                  rw,
        input logic                  vs
    );
        return rw && (wa == a) && (vs == v);
    endfunction

    function automatic logic [1:0] f_fwd_sel(
        input logic [REG_ADDR_W-1:0] ra
    );
        if (f_match(ra, i_v_s_e, i_wa3m, i_reg_write_m, i_v_s_m))
            return 2'b10;
        else if (f_match(ra, i_v_s_e, i_wa3w, i_reg_write_w, i_v_s_w))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_vec_e = i_valid_e && i_v_s_e && (PASSES > 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_pass_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pass_cnt <= w_pass_cnt_nxt;
        end
    end

    // Pass 0 runs while still in IDLE, so VEXEC only covers passes 1..PASSES-1.
    always_comb begin
        w_state_nxt    = r_state;
        w_pass_cnt_nxt = r_pass_cnt;
        w_seq_stall    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vec_e) begin
                    w_seq_stall    = 1'b1;
                    w_pass_cnt_nxt = GRP_W'(1);
                    w_state_nxt    = ST_VEXEC;
                end
            end
            ST_VEXEC: begin
                if (r_pass_cnt == GRP_W'(PASSES - 1)) begin
                    w_state_nxt    = ST_IDLE;
                    w_pass_cnt_nxt = '0;
                end else begin
                    w_seq_stall    = 1'b1;
                    w_pass_cnt_nxt = r_pass_cnt + GRP_W'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_pass_cnt_nxt = '0;
            end
        endcase
    end

    assign w_ldstall = i_valid_e && i_mem_to_reg_e && i_reg_write_e &&
                       (i_v_s_e == i_v_s_d) &&
                       ((i_wa3e == i_ra1d) || (i_wa3e == i_ra2d));

    // A redirect squashes D anyway, so it cancels the load-use stall; the
    // vector sequence overrides both (a redirect with a vector in E is ignored).
    assign w_stall_f = w_seq_stall | (w_ldstall & ~i_pcsrc_e);

    // Combinational outputs are forced low while reset is held.
    assign o_stall_f    = ~i_rst & w_stall_f;
    assign o_stall_d    = ~i_rst & w_stall_f;
    assign o_stall_e    = ~i_rst & w_seq_stall;
    assign o_bubble_m   = ~i_rst & w_seq_stall;
    assign o_flush_d    = ~i_rst & i_pcsrc_e & ~w_seq_stall;
    assign o_flush_e    = ~i_rst & (w_ldstall | i_pcsrc_e) & ~w_seq_stall;
    assign o_forward_ae = i_rst ? 2'b00 : f_fwd_sel(i_ra1e);
    assign o_forward_be = i_rst ? 2'b00 : f_fwd_sel(i_ra2e);

    // Decoded from registers only so these never glitch on input changes.
    assign o_lane_grp = (r_state == ST_VEXEC) ? r_pass_cnt : '0;
    assign o_vec_busy = (r_state == ST_VEXEC);

endmodule

// File: tb/tb_pipe_hazard_sched.sv
module tb_pipe_hazard_sched;

    localparam int P = 4;   // passes with the default lane configuration

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ra1d, ra2d, wa3e, ra1e, ra2e, wa3m, wa3w;
    logic       v_s_d, valid_e, reg_write_e, mem_to_reg_e, v_s_e, pcsrc_e;
    logic       reg_write_m, reg_write_w, v_s_m, v_s_w;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, vec_busy;
    logic [1:0] fwd_ae, fwd_be, lane_grp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_sched dut (
        .i_clk(clk), .i_rst(rst),
        .i_ra1d(ra1d), .i_ra2d(ra2d), .i_v_s_d(v_s_d),
        .i_valid_e(valid_e), .i_wa3e(wa3e), .i_reg_write_e(reg_write_e),
        .i_mem_to_reg_e(mem_to_reg_e), .i_v_s_e(v_s_e), .i_pcsrc_e(pcsrc_e),
        .i_ra1e(ra1e), .i_ra2e(ra2e), .i_wa3m(wa3m), .i_wa3w(wa3w),
        .i_reg_write_m(reg_write_m), .i_reg_write_w(reg_write_w),
        .i_v_s_m(v_s_m), .i_v_s_w(v_s_w),
        .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e),
        .o_flush_d(flush_d), .o_flush_e(flush_e), .o_bubble_m(bubble_m),
        .o_forward_ae(fwd_ae), .o_forward_be(fwd_be),
        .o_lane_grp(lane_grp), .o_vec_busy(vec_busy)
    );

    logic [12:0] act_bus;
    assign act_bus = {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m,
                      fwd_ae, fwd_be, lane_grp, vec_busy};

    // ---------------- reference model ----------------
    // k = index of the pass the E-stage vector op performs in the sequence
    // after pass 0 (0 means no sequence in flight).
    function automatic logic [1:0] m_fwd(input logic [3:0] ra);
        if (reg_write_m && wa3m == ra && v_s_m == v_s_e) return 2'b10;
        if (reg_write_w && wa3w == ra && v_s_w == v_s_e) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [12:0] m_out(input int k);
        logic seq, ld, sf;
        if (rst) return 13'd0;
        if (k > 0) seq = (k < P - 1);
        else       seq = valid_e && v_s_e;
        ld = valid_e && mem_to_reg_e && reg_write_e && (v_s_e == v_s_d) &&
             (wa3e == ra1d || wa3e == ra2d);
        sf = seq || (ld && !pcsrc_e);
        return {sf, sf, seq, pcsrc_e && !seq, (ld || pcsrc_e) && !seq, seq,
                m_fwd(ra1e), m_fwd(ra2e), 2'(k), k > 0};
    endfunction

    function automatic int m_next(input int k);
        if (rst) return 0;
        if (k > 0) return (k == P - 1) ? 0 : k + 1;
        return (valid_e && v_s_e) ? 1 : 0;
    endfunction

    initial begin : compare
        int k;
        logic [12:0] e;
        k = 0;
        forever begin
            @(negedge clk);
            e = m_out(k);
            n_checks++;
            if (act_bus !== e) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act_bus, e);
            end
            @(posedge clk);
            k = m_next(k);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {ra1d, ra2d, wa3e, ra1e, ra2e, wa3m, wa3w} = '0;
        {v_s_d, valid_e, reg_write_e, mem_to_reg_e, v_s_e, pcsrc_e} = '0;
        {reg_write_m, reg_write_w, v_s_m, v_s_w} = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [3:0] t3_stall;
        logic [3:0] t3_busy;
        t3_stall = 4'b0111;
        t3_busy  = 4'b1110;

        // Reset with busy-looking inputs: every output must still be 0.
        clr();
        rst = 1'b1;
        valid_e = 1'b1; v_s_e = 1'b1; pcsrc_e = 1'b1;
        reg_write_m = 1'b1; wa3m = 4'd0;
        @(negedge clk);
        chk("reset_outputs", act_bus, 13'd0);
        cyc();
        rst = 1'b0;
        clr();

        // T1 forwarding priority
        wa3m = 4'd3; wa3w = 4'd3; reg_write_m = 1'b1; reg_write_w = 1'b1; ra1e = 4'd3;
        @(negedge clk);
        chk("t1_fwd_m", 13'(fwd_ae), 13'(2'b10));
        chk("t1_fwd_b_none", 13'(fwd_be), 13'(2'b00));
        cyc();
        reg_write_m = 1'b0;
        @(negedge clk);
        chk("t1_fwd_w", 13'(fwd_ae), 13'(2'b01));
        cyc();
        reg_write_m = 1'b1; v_s_m = 1'b1;
        @(negedge clk);
        chk("t1_fwd_class", 13'(fwd_ae), 13'(2'b01));
        cyc();
        clr();

        // T2 load-use
        valid_e = 1'b1; mem_to_reg_e = 1'b1; reg_write_e = 1'b1; wa3e = 4'd5; ra2d = 4'd5;
        @(negedge clk);
        chk("t2_ldstall", 13'({stall_f, stall_d, flush_e, stall_e}), 13'(4'b1110));
        cyc();
        valid_e = 1'b0;
        @(negedge clk);
        chk("t2_after_bubble", 13'({stall_f, stall_d, flush_e}), 13'd0);
        cyc();
        valid_e = 1'b1; v_s_d = 1'b1;
        @(negedge clk);
        chk("t2_class_nostall", 13'({stall_f, stall_d, flush_e}), 13'd0);
        cyc();
        clr();

        // T3 single vector op
        valid_e = 1'b1; v_s_e = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("t3_c%0d", c), 13'({lane_grp, stall_e, bubble_m, vec_busy}),
                13'({2'(c), t3_stall[c], t3_stall[c], t3_busy[c]}));
            cyc();
        end
        valid_e = 1'b0;
        @(negedge clk);
        chk("t3_done", 13'({lane_grp, vec_busy, stall_e}), 13'd0);
        cyc();

        // T4 back-to-back vector ops
        valid_e = 1'b1; v_s_e = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t4_c%0d", c), 13'({lane_grp, stall_e}),
                13'({2'(c % 4), (c % 4) != 3}));
            cyc();
        end
        clr();
        cyc();

        // T5 branch overrides load-use
        valid_e = 1'b1; mem_to_reg_e = 1'b1; reg_write_e = 1'b1; wa3e = 4'd7; ra1d = 4'd7;
        pcsrc_e = 1'b1;
        @(negedge clk);
        chk("t5_branch", 13'({flush_d, flush_e, stall_f, stall_d}), 13'(4'b1100));
        cyc();
        clr();

        // T6 reset mid-sequence, then replay from pass 0
        valid_e = 1'b1; v_s_e = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("t6_at_grp2", 13'(lane_grp), 13'd2);
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", act_bus, 13'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_replay_p0", 13'({lane_grp, vec_busy, stall_e}), 13'(4'b0001));
        cyc();
        @(negedge clk);
        chk("t6_replay_p1", 13'({lane_grp, vec_busy}), 13'(3'b011));
        cyc();
        clr();

        // Randomized traffic checked by the model process
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            ra1d         = 4'($urandom_range(0, 3));
            ra2d         = 4'($urandom_range(0, 3));
            wa3e         = 4'($urandom_range(0, 3));
            ra1e         = 4'($urandom_range(0, 3));
            ra2e         = 4'($urandom_range(0, 3));
            wa3m         = 4'($urandom_range(0, 3));
            wa3w         = 4'($urandom_range(0, 3));
            v_s_d        = 1'($urandom);
            valid_e      = ($urandom_range(0, 3) != 0);
            reg_write_e  = 1'($urandom);
            mem_to_reg_e = 1'($urandom);
            v_s_e        = ($urandom_range(0, 2) == 0);
            pcsrc_e      = ($urandom_range(0, 7) == 0);
            reg_write_m  = 1'($urandom);
            reg_write_w  = 1'($urandom);
            v_s_m        = 1'($urandom);
            v_s_w        = 1'($urandom);
            cyc();
        end
        rst = 1'b0;
        clr();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
